// File: rtl/router_pkg.sv
// Shared definitions for the router packet source.
// Contents: source FSM state enum, illegal destination code, default LFSR
// feedback mask, header length-field width and the Galois LFSR step helper.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } src_state_t;

    localparam logic [1:0] ADDR_ILLEGAL      = 2'b11;
    localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'hB8;
    localparam int         HDR_LEN_W         = 6;

    // One Galois step: shift right, fold the mask in when a 1 falls out.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] v,
                                              input logic [7:0] taps);
        return (v >> 1) ^ (v[0] ? taps : 8'h00);
    endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Galois LFSR used as the payload byte generator.
// Ports: clk/reset (async, active high), load + seed (takes priority over
// step), step (advance one position), q (current value, resets to 8'h01).
module router_lfsr8
    import router_pkg::*;
#(
    parameter logic [7:0] TAPS = LFSR_TAPS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     q <= 8'h01;
        else if (load) q <= seed;
        else if (step) q <= lfsr8_next(q, TAPS);
    end

endmodule

// File: rtl/router_pkt_src.sv
// Packet source feeding router_top's pkt_valid/data_in protocol.
// Inputs : clk, reset (async, active high), start/addr/payload_len/seed
//          request, busy backpressure from the router.
// Outputs: ready (idle), pkt_valid/pkt_data (header, payload, parity),
//          done pulse, req_err pulse, pkt_count (completed packets).
// All outputs are registered: the output comb computes next-cycle values
// from the next state, and a single register stage drives the ports.
module router_pkt_src
    import router_pkg::*;
#(
    parameter logic [7:0] LFSR_TAPS = LFSR_TAPS_DEFAULT,
    parameter int         CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           addr,
    input  logic [HDR_LEN_W-1:0] payload_len,
    input  logic [7:0]           seed,
    input  logic                 busy,
    output logic                 ready,
    output logic                 pkt_valid,
    output logic [7:0]           pkt_data,
    output logic                 done,
    output logic                 req_err,
    output logic [CNT_W-1:0]     pkt_count
);

    src_state_t           state, state_d;
    logic [1:0]           addr_q;
    logic [HDR_LEN_W-1:0] len_q, cnt_q;
    logic [7:0]           par_q, lfsr_q, seed_sub;
    logic                 accept, reject, in_pkt, xfer, last_pay;
    logic                 pkt_valid_d, done_d, ready_d;
    logic [7:0]           pkt_data_d;

    assign accept   = (state == IDLE) && start && (addr != ADDR_ILLEGAL);
    assign reject   = (state == IDLE) && start && (addr == ADDR_ILLEGAL);
    assign in_pkt   = (state == HEADER) || (state == PAYLOAD) || (state == PARITY);
    assign xfer     = in_pkt && !busy;
    assign last_pay = (cnt_q + 1'b1) == len_q;
    assign seed_sub = (seed == 8'h00) ? 8'h01 : seed;

    router_lfsr8 #(.TAPS(LFSR_TAPS)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .seed  (seed_sub),
        .step  ((state == PAYLOAD) && !busy),
        .q     (lfsr_q)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = HEADER;
            HEADER:  if (!busy) state_d = (len_q == '0) ? PARITY : PAYLOAD;
            PAYLOAD: if (!busy && last_pay) state_d = PARITY;
            PARITY:  if (!busy) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic (next-cycle values of the registered ports)
    always_comb begin
        pkt_valid_d = (state_d == HEADER) || (state_d == PAYLOAD);
        done_d      = (state_d == GAP);
        ready_d     = (state_d == IDLE);
        pkt_data_d  = 8'h00;
        if (in_pkt && busy) begin
            pkt_data_d = pkt_data;
        end else begin
            case (state_d)
                // Only entered from IDLE, so the header comes from the request.
                HEADER:  pkt_data_d = {payload_len, addr};
                // lfsr_q already holds the seed on the first payload byte.
                PAYLOAD: pkt_data_d = (state == HEADER) ? lfsr_q
                                                        : lfsr8_next(lfsr_q, LFSR_TAPS);
                // Fold in the byte being transferred on this edge.
                PARITY:  pkt_data_d = par_q ^ pkt_data;
                default: pkt_data_d = 8'h00;
            endcase
        end
    end

    // Request latch, byte counter, running parity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            par_q  <= '0;
        end else if (accept) begin
            addr_q <= addr;
            len_q  <= payload_len;
            cnt_q  <= '0;
            par_q  <= '0;
        end else if (xfer && state != PARITY) begin
            par_q <= par_q ^ pkt_data;
            if (state == PAYLOAD) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready     <= 1'b1;
            pkt_valid <= 1'b0;
            pkt_data  <= 8'h00;
            done      <= 1'b0;
            req_err   <= 1'b0;
            pkt_count <= '0;
        end else begin
            ready     <= ready_d;
            pkt_valid <= pkt_valid_d;
            pkt_data  <= pkt_data_d;
            done      <= done_d;
            req_err   <= reject;
            if (done_d) pkt_count <= pkt_count + 1'b1;
        end
    end

endmodule

// File: doc/router_pkt_src.md
# router_pkt_src

Synthesizable packet source that sits directly upstream of `router_top` and drives its `pkt_valid` / `data_in` input protocol. It accepts one packet request at a time (destination, payload length, payload seed) and emits the header byte, LFSR-generated payload bytes and a trailing XOR parity byte. It stalls on the router's `busy` and inserts a one-cycle gap between packets. It is used in self-checking system benches and in FPGA bring-up in place of a hand-written stimulus task.

## Interface
Parameters:
- `LFSR_TAPS`, default `8'hB8`: Galois LFSR feedback mask (x^8+x^6+x^5+x^4+1).
- `CNT_W`, default `16`: width of the packet counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request strobe; sampled only when `ready`=1.
- `addr` in 2: destination port; `2'b11` is illegal.
- `payload_len` in 6: payload byte count, 0..63. 0 is legal.
- `seed` in 8: first payload byte and LFSR seed. `8'h00` is replaced by `8'h01`.
- `busy` in 1: router backpressure, from `router_top.busy`.
- `ready` out 1: high only in IDLE.
- `pkt_valid` out 1: to `router_top.pkt_valid`.
- `pkt_data` out 8: to `router_top.data_in`.
- `done` out 1: one-cycle pulse after the parity byte is transferred.
- `req_err` out 1: one-cycle pulse when a request with `addr`=3 is rejected.
- `pkt_count` out CNT_W: packets completed, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - `ready`=1, `pkt_valid`=0, `pkt_data`=0.
  - `start`=1 with legal `addr`: latch `addr`, `payload_len` and the substituted `seed`; go to HEADER.
  - `start`=1 with `addr`=3: pulse `req_err` next cycle and stay in IDLE.
- HEADER:
  - Drive `pkt_data`={`payload_len`,`addr`}, `pkt_valid`=1.
  - On transfer, go to PAYLOAD, or to PARITY if `payload_len`=0.
- PAYLOAD:
  - Drive `pkt_data`=lfsr, `pkt_valid`=1.
  - On transfer, advance the LFSR and increment the byte counter.
  - After the `payload_len`-th transfer, go to PARITY.
- PARITY:
  - Drive `pkt_data`=parity, `pkt_valid`=0. The router convention is that `pkt_valid` falls with the parity byte.
  - On transfer, go to GAP.
- GAP:
  - `pkt_valid`=0, `pkt_data`=0, `done`=1, `pkt_count`+1.
  - Return to IDLE next cycle unconditionally.
- Transfer: a rising edge in HEADER, PAYLOAD or PARITY with `busy`=0. With `busy`=1, the state, `pkt_data`, `pkt_valid`, LFSR and parity all hold.
- Parity: XOR of the header and every payload byte, accumulated at each transfer and cleared on request accept.
- LFSR step: `lfsr` = (`lfsr`>>1) ^ (`lfsr`[0] ? LFSR_TAPS : 0). It never reaches 0 because the seed is nonzero.

## Timing
- Reset values: `ready`=1 (IDLE); `pkt_valid`, `pkt_data`, `done`, `req_err` and `pkt_count` are all 0. LFSR is 8'h01; parity and byte counter are 0.
- Reset asserted mid-packet aborts immediately; no parity byte is sent.
- All outputs are registered.
- Latencies:
  - `start` accepted at edge N → header on `pkt_data` from N+1.
  - No stall: packet occupies N+1 .. N+2+`payload_len`; `done` at N+3+`payload_len`; `ready` at N+4+`payload_len`.
  - Minimum issue interval is `payload_len`+4 cycles.
- `start` while `ready`=0 is ignored; no queuing.
- `busy` is sampled every cycle, including the first header cycle. It is ignored in IDLE and GAP.
- A `busy` deasserting and re-asserting on consecutive edges transfers exactly one byte.
- `payload_len`=63 is the 6-bit maximum; the byte counter is 6 bits and compares against the latched length, so there is no wrap.

## Structure
- Shared package `router_pkg`:
  - state enum `src_state_t` {IDLE, HEADER, PAYLOAD, PARITY, GAP};
  - `ADDR_ILLEGAL` = 2'b11;
  - `LFSR_TAPS_DEFAULT` = 8'hB8;
  - `HDR_LEN_W` = 6.
- One sub-module, `router_lfsr8`: ports `load`, `seed`, `step`, `q`, parameter `TAPS`.
- FSM, counters and parity live in `router_pkt_src`.

## Test plan
- `addr`=0, `payload_len`=1, `seed`=8'h5A, `busy`=0 → `pkt_data` 8'h04, 8'h5A (`pkt_valid`=1), then 8'h5E (`pkt_valid`=0); `done` 3 cycles after the header; `pkt_count`=1.
- `addr`=1, `payload_len`=2, `seed`=8'h00 → header 8'h09, payload 8'h01, 8'hB8, parity 8'hB0.
- `addr`=2, `payload_len`=0, `seed` don't-care → header 8'h02 with `pkt_valid`=1, then parity 8'h02 with `pkt_valid`=0; `done` next.
- Repeat the first case with `busy`=1 for 3 cycles during the payload byte → 8'h5A held 4 cycles; parity is still 8'h5E; `done` is delayed by 3.
- `start` with `addr`=3 → `req_err` pulse one cycle later, `pkt_valid` stays 0, `ready` stays 1, `pkt_count` unchanged.
- Assert `reset` during the second payload byte of a 6-byte packet → `pkt_valid`/`pkt_data` go to 0 asynchronously and `ready`=1. A new request afterwards produces a correct packet with `pkt_count`=1.
